// File: rtl/rti_pkg.sv
// rti_pkg: shared command/state encodings and the timeout result word for the FPRTI issue controller
package rti_pkg;
  typedef enum logic [1:0] {
    CMD_WR_REG = 2'd0,
    CMD_RD_REG = 2'd1,
    CMD_LAUNCH = 2'd2,
    CMD_RSVD   = 2'd3
  } cmd_e;
  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_e;
  localparam logic [31:0] TIMEOUT_RESULT = 32'hFFFF_FFFF;
endpackage

// File: rtl/fprti_regfile.sv
// fprti_regfile: operand registers with one write port, one read port and a full parallel view
module fprti_regfile #(
  parameter int N = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [3:0]         waddr,
  input  logic [31:0]        wdata,
  input  logic [3:0]         raddr,
  output logic [31:0]        rdata,
  output logic [N-1:0][31:0] regs
);
  // Registers clear on reset and take a write only for an index that exists
  always_ff @(posedge clk) begin
    if (!rst_n) regs <= '0;
    else if (we && int'(waddr) < N) regs[waddr] <= wdata;
  end
  assign rdata = int'(raddr) < N ? regs[raddr] : '0;
endmodule

// File: rtl/fprti_issue_ctrl.sv
// fprti_issue_ctrl: accepts core commands, owns the operand registers and sequences engine launches
module fprti_issue_ctrl
  import rti_pkg::*;
#(
  parameter int NUM_FPRTI_REGS = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_i,
  input  logic [1:0]                      cmd_i,
  input  logic [3:0]                      addr_i,
  input  logic [31:0]                     wdata_i,
  output logic                            gnt_o,
  output logic                            rvalid_o,
  output logic [31:0]                     rdata_o,
  output logic                            err_o,
  output logic                            busy_o,
  output logic [NUM_FPRTI_REGS-1:0][31:0] fprti_regs_o,
  output logic                            input_valid_o,
  input  logic [31:0]                     return_i,
  input  logic                            output_valid_i
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  state_e state, state_nx;
  cmd_e cmd;
  logic [CW-1:0] cnt;
  logic [31:0] rf_rdata;
  logic ready, rd_q, timeout;
  assign cmd = cmd_e'(cmd_i);
  assign timeout = cnt == CNT_LAST;
  assign busy_o = rst_n & (state != S_IDLE);
  assign input_valid_o = rst_n & (state == S_LAUNCH);
  assign rvalid_o = rst_n & ((state == S_RESP) | rd_q);
  fprti_regfile #(.N(NUM_FPRTI_REGS)) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (gnt_o && cmd == CMD_WR_REG),
    .waddr (addr_i),
    .wdata (wdata_i),
    .raddr (addr_i),
    .rdata (rf_rdata),
    .regs  (fprti_regs_o)
  );
  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  end
  // Grant only in IDLE once the cycle after reset has passed; a launch moves through the engine handshake
  always_comb begin
    state_nx = state;
    gnt_o = 1'b0;
    case (state)
      S_IDLE: begin
        gnt_o = rst_n & ready & req_i;
        state_nx = (gnt_o && cmd == CMD_LAUNCH) ? S_LAUNCH : S_IDLE;
      end
      S_LAUNCH: state_nx = S_WAIT;
      S_WAIT:   state_nx = (output_valid_i || timeout) ? S_RESP : S_WAIT;
      default:  state_nx = S_IDLE;
    endcase
  end
  // Response capture and wait counter; an engine result beats a same-cycle timeout
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready <= 1'b0;
      rd_q <= 1'b0;
      cnt <= '0;
      rdata_o <= '0;
      err_o <= 1'b0;
    end else begin
      ready <= 1'b1;
      rd_q <= gnt_o && cmd == CMD_RD_REG;
      cnt <= state == S_WAIT ? cnt + 1'b1 : '0;
      if (gnt_o && cmd == CMD_RD_REG) begin
        rdata_o <= rf_rdata;
        err_o <= 1'b0;
      end else if (state == S_WAIT && output_valid_i) begin
        rdata_o <= return_i;
        err_o <= 1'b0;
      end else if (state == S_WAIT && timeout) begin
        rdata_o <= TIMEOUT_RESULT;
        err_o <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fprti_issue_ctrl.sv
// tb_fprti_issue_ctrl: vector table, directed corner sequences and a randomized run against a transaction-level model
module tb_fprti_issue_ctrl;
  localparam int T = 16;
  typedef struct {
    logic [1:0]  cmd;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, req = 1'b0, ov = 1'b0;
  logic [1:0] cmd = '0;
  logic [3:0] addr = '0;
  logic [31:0] wdata = '0, ret = '0;
  logic gnt, rvalid, err, busy, ivalid;
  logic [31:0] rdata;
  logic [15:0][31:0] regs;
  int checks = 0, failures = 0;
  vec_t tbl[20];
  logic [31:0] m_regs[16];

  always #5 clk = ~clk;

  fprti_issue_ctrl #(.NUM_FPRTI_REGS(16), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .cmd_i(cmd), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err), .busy_o(busy),
    .fprti_regs_o(regs), .input_valid_o(ivalid), .return_i(ret), .output_valid_i(ov)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic r, input logic [1:0] c, input logic [3:0] a, input logic [31:0] w,
                     input logic o, input logic [31:0] rt);
    @(negedge clk);
    req = r; cmd = c; addr = a; wdata = w; ov = o; ret = rt;
    #1;
  endtask

  function automatic vec_t mk(input logic [1:0] c, input logic [3:0] a, input logic [31:0] w,
                              input logic rv, input logic [31:0] rd);
    vec_t v;
    v.cmd = c; v.addr = a; v.wdata = w; v.gnt = 1'b1; v.rv = rv; v.rd = rd;
    return v;
  endfunction

  // Launch, let the engine answer lat cycles after the launch pulse (0 = never), report response timing
  task automatic launch_run(input int lat, input logic [31:0] val, input string nm,
                            output int rv_at, output logic [31:0] rd, output logic er);
    int pulses;
    pulses = 0; rv_at = -1; rd = '0; er = 1'b0;
    drv(1'b1, 2'd2, 4'd0, 32'd0, 1'b0, 32'd0);
    chk({nm, "_gnt"}, 32'(gnt), 32'd1);
    for (int t = 1; t <= 40 && rv_at < 0; t++) begin
      drv(1'b0, 2'd0, 4'd0, 32'd0, lat > 0 && t == 1 + lat, val);
      if (ivalid) pulses++;
      if (rvalid) begin
        rv_at = t; rd = rdata; er = err;
      end
    end
    chk({nm, "_pulses"}, 32'(pulses), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rv_at, bad, launch_c, resp_c, ov_c, rd_c, lat;
    logic [31:0] rd, resp_d, ov_d, rd_d, e_rd, w, rt;
    logic er, resp_e, e_er, r, o, busy_e, in_wait;
    logic [1:0] c;
    logic [3:0] a;
    // reset, then the first cycle after reset must refuse a request
    repeat (2) @(negedge clk);
    drv(1'b1, 2'd0, 4'd0, 32'h5, 1'b0, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ivalid", 32'(ivalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    drv(1'b0, 2'd0, 4'd0, 32'd0, 1'b0, 32'd0);
    chk("rst_regs_zero", 32'(regs == '0), 32'd1);
    // vector table: 15 writes, reads, reserved command
    for (int i = 0; i < 15; i++) tbl[i] = mk(2'd0, 4'(i), 32'h3F80_0000 + 32'(i), 1'b0, 32'd0);
    tbl[15] = mk(2'd1, 4'd7, 32'd0, 1'b1, 32'h3F80_0007);
    tbl[16] = mk(2'd1, 4'd14, 32'd0, 1'b1, 32'h3F80_000E);
    tbl[17] = mk(2'd1, 4'd15, 32'd0, 1'b1, 32'd0);
    tbl[18] = mk(2'd3, 4'd0, 32'hDEAD_BEEF, 1'b0, 32'd0);
    tbl[19] = mk(2'd1, 4'd0, 32'd0, 1'b1, 32'h3F80_0000);
    for (int i = 0; i <= 20; i++) begin
      if (i < 20) drv(1'b1, tbl[i].cmd, tbl[i].addr, tbl[i].wdata, 1'b0, 32'd0);
      else drv(1'b0, 2'd0, 4'd0, 32'd0, 1'b0, 32'd0);
      if (i < 20) chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      if (i > 0) begin
        chk($sformatf("tbl%0d_rvalid", i - 1), 32'(rvalid), 32'(tbl[i-1].rv));
        if (tbl[i-1].rv) begin
          chk($sformatf("tbl%0d_rdata", i - 1), rdata, tbl[i-1].rd);
          chk($sformatf("tbl%0d_err", i - 1), 32'(err), 32'd0);
        end
      end
    end
    chk("tbl_reg0_unchanged", regs[0], 32'h3F80_0000);
    // engine answers 5 cycles after the launch pulse
    launch_run(5, 32'h4120_0000, "eng5", rv_at, rd, er);
    chk("eng5_latency", 32'(rv_at), 32'd7);
    chk("eng5_rdata", rd, 32'h4120_0000);
    chk("eng5_err", 32'(er), 32'd0);
    drv(1'b0, 2'd0, 4'd0, 32'd0, 1'b0, 32'd0);
    chk("eng5_rvalid_one", 32'(rvalid), 32'd0);
    chk("eng5_rdata_hold", rdata, 32'h4120_0000);
    // fastest engine
    launch_run(1, 32'h0000_00AA, "eng1", rv_at, rd, er);
    chk("eng1_latency", 32'(rv_at), 32'd3);
    chk("eng1_rdata", rd, 32'h0000_00AA);
    // silent engine times out
    launch_run(0, 32'd0, "tmo", rv_at, rd, er);
    chk("tmo_latency", 32'(rv_at), 32'(T + 2));
    chk("tmo_rdata", rd, 32'hFFFF_FFFF);
    chk("tmo_err", 32'(er), 32'd1);
    drv(1'b0, 2'd0, 4'd0, 32'd0, 1'b0, 32'd0);
    chk("tmo_idle", 32'(busy), 32'd0);
    // result on the final timeout cycle wins
    launch_run(T, 32'h1234_5678, "race", rv_at, rd, er);
    chk("race_latency", 32'(rv_at), 32'(T + 2));
    chk("race_rdata", rd, 32'h1234_5678);
    chk("race_err", 32'(er), 32'd0);
    chk("ops_regs_unchanged", regs[7], 32'h3F80_0007);
    // write held across a launch is granted only the cycle after RESP
    drv(1'b1, 2'd2, 4'd0, 32'd0, 1'b0, 32'd0);
    chk("hold_launch_gnt", 32'(gnt), 32'd1);
    for (int t = 1; t <= 7; t++) begin
      drv(1'b1, 2'd0, 4'd3, 32'hCAFE_0003, t == 5, 32'h7);
      chk($sformatf("hold_gnt_t%0d", t), 32'(gnt), 32'(t == 7));
      if (t == 6) chk("hold_rvalid", 32'(rvalid), 32'd1);
      if (t < 7) chk($sformatf("hold_reg_t%0d", t), regs[3], 32'h3F80_0003);
    end
    drv(1'b0, 2'd0, 4'd0, 32'd0, 1'b0, 32'd0);
    chk("hold_reg_updated", regs[3], 32'hCAFE_0003);
    // reset during WAIT aborts; a stray result afterwards is ignored
    drv(1'b1, 2'd2, 4'd0, 32'd0, 1'b0, 32'd0);
    chk("abort_gnt", 32'(gnt), 32'd1);
    repeat (2) drv(1'b0, 2'd0, 4'd0, 32'd0, 1'b0, 32'd0);
    chk("abort_in_wait", 32'(busy), 32'd1);
    drv(1'b0, 2'd0, 4'd0, 32'd0, 1'b0, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_rst_busy", 32'(busy), 32'd0);
    chk("abort_rst_rvalid", 32'(rvalid), 32'd0);
    drv(1'b0, 2'd0, 4'd0, 32'd0, 1'b1, 32'hDEAD_0001);
    rst_n = 1'b1;
    #1;
    bad = 0;
    for (int t = 0; t < 6; t++) begin
      if (t > 0) drv(1'b0, 2'd0, 4'd0, 32'd0, 1'b1, 32'hDEAD_0001);
      if (rvalid || busy || ivalid) bad++;
    end
    chk("abort_no_activity", 32'(bad), 32'd0);
    chk("abort_regs_zero", 32'(regs == '0), 32'd1);
    chk("abort_rdata", rdata, 32'd0);
    // randomized run against a transaction-level model
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    launch_c = -100; resp_c = -100; ov_c = -100; rd_c = -100;
    resp_d = '0; ov_d = '0; rd_d = '0; resp_e = 1'b0; e_rd = '0; e_er = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 9) < 6;
      c = 2'($urandom_range(0, 3));
      a = 4'($urandom_range(0, 15));
      w = $urandom;
      in_wait = k > launch_c && k < resp_c;
      o = (k == ov_c) || (!in_wait && $urandom_range(0, 7) == 0);
      rt = k == ov_c ? ov_d : $urandom;
      drv(r, c, a, w, o, rt);
      busy_e = k >= launch_c && k <= resp_c;
      if (k == rd_c) begin e_rd = rd_d; e_er = 1'b0; end
      if (k == resp_c) begin e_rd = resp_d; e_er = resp_e; end
      chk("rnd_gnt", 32'(gnt), 32'(r && !busy_e));
      chk("rnd_busy", 32'(busy), 32'(busy_e));
      chk("rnd_ivalid", 32'(ivalid), 32'(k == launch_c));
      chk("rnd_rvalid", 32'(rvalid), 32'(k == rd_c || k == resp_c));
      chk("rnd_rdata", rdata, e_rd);
      chk("rnd_err", 32'(err), 32'(e_er));
      if (k % 50 == 0) chk($sformatf("rnd_reg%0d", a), regs[a], m_regs[a]);
      if (r && !busy_e) begin
        if (c == 2'd0) m_regs[a] = w;
        else if (c == 2'd1) begin
          rd_c = k + 1; rd_d = m_regs[a];
        end else if (c == 2'd2) begin
          lat = $urandom_range(1, T + 1);
          launch_c = k + 1;
          ov_c = k + 1 + lat;
          ov_d = $urandom;
          resp_c = k + 2 + (lat < T ? lat : T);
          resp_d = lat <= T ? ov_d : 32'hFFFF_FFFF;
          resp_e = lat > T;
        end
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fprti_issue_ctrl.md
FPRTI_ISSUE_CTRL -- requirements
Module: fprti_issue_ctrl

Interface
REQ-001 Parameter NUM_FPRTI_REGS, default 16: number of 32-bit operand registers driven to the intersection engine.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: maximum WAIT cycles before a forced error response.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 req_i  input  1  core command request.
REQ-006 cmd_i  input  2  command: WR_REG=0, RD_REG=1, LAUNCH=2, 3 reserved.
REQ-007 addr_i  input  4  operand register index for WR_REG/RD_REG.
REQ-008 wdata_i  input  32  write data for WR_REG.
REQ-009 gnt_o  output  1  command accepted this cycle.
REQ-010 rvalid_o  output  1  one-cycle response strobe; no backpressure.
REQ-011 rdata_o  output  32  response data, valid with rvalid_o.
REQ-012 err_o  output  1  response is a timeout error, valid with rvalid_o.
REQ-013 busy_o  output  1  high in states LAUNCH, WAIT, RESP.
REQ-014 fprti_regs_o  output  NUM_FPRTI_REGS x 32  operand registers to the engine, driven directly from flops.
REQ-015 input_valid_o  output  1  one-cycle launch pulse to the engine.
REQ-016 return_i  input  32  engine result.
REQ-017 output_valid_i  input  1  engine result strobe.

Function
REQ-018 States: IDLE, LAUNCH, WAIT, RESP; transitions only as stated below.
REQ-019 IDLE: gnt_o = req_i when cmd_i is 0..2; reserved cmd gets gnt_o=1 and is discarded with no response.
REQ-020 WR_REG granted: fprti_regs_o[addr_i] takes wdata_i at the granting edge, visible the next cycle; no response.
REQ-021 RD_REG granted: rvalid_o=1 the next cycle with rdata_o = register value before any same-edge write, err_o=0.
REQ-022 LAUNCH granted: IDLE->LAUNCH; in LAUNCH input_valid_o=1 for exactly one cycle, then ->WAIT with timeout counter cleared.
REQ-023 LAUNCH, WAIT, RESP: gnt_o=0; requests stall and the core holds them.
REQ-024 WAIT: counter increments each cycle; output_valid_i=1 captures return_i into rdata, err=0, ->RESP.
REQ-025 WAIT: counter reaching TIMEOUT_CYCLES-1 with no output_valid_i sets rdata=32'hFFFF_FFFF, err=1, ->RESP.
REQ-026 If output_valid_i and timeout occur in the same cycle, the result wins (err=0).
REQ-027 RESP: rvalid_o=1 for exactly one cycle with captured rdata_o/err_o, then ->IDLE; a new command may be granted on the following cycle.
REQ-028 output_valid_i outside WAIT is ignored; it does not change state, data or err.
REQ-029 Launch-to-response latency = engine latency + 2 cycles (LAUNCH cycle, RESP cycle); minimum 3 when the engine answers in the first WAIT cycle.
REQ-030 Outside RESP and the RD_REG response cycle, rvalid_o=0 and rdata_o/err_o hold their last values.
REQ-031 Operand registers are unchanged by LAUNCH, WAIT and RESP; the engine may re-sample them at any time.

Reset
REQ-032 rst_n=0 at a clock edge: state=IDLE, all fprti_regs_o=0, counter=0, rdata_o=0, err_o=0.
REQ-033 During reset and the first cycle after it: gnt_o=0, rvalid_o=0, input_valid_o=0, busy_o=0.
REQ-034 Reset mid-operation (LAUNCH/WAIT/RESP) aborts with no response; a later output_valid_i is ignored per REQ-028.

Structure
REQ-035 Shared package rti_pkg holds the command enum, the state enum, and TIMEOUT_RESULT=32'hFFFF_FFFF.
REQ-036 Counter width = $clog2(TIMEOUT_CYCLES+1), local to the module.
REQ-037 Operand storage is one sub-module, fprti_regfile: single write port, one read port, full parallel output.

Verification
REQ-038 Write 15 registers with 32'h3F80_0000+i, RD_REG addr 7 -> rvalid next cycle, rdata=32'h3F80_0007, err=0.
REQ-039 LAUNCH; engine model returns 32'h4120_0000 after 5 cycles -> one input_valid_o pulse, rvalid 7 cycles after grant, rdata=32'h4120_0000, err=0.
REQ-040 LAUNCH with engine silent, TIMEOUT_CYCLES=16 -> rvalid with rdata=32'hFFFF_FFFF, err=1, state back to IDLE.
REQ-041 output_valid_i asserted on the final timeout cycle with return_i=32'h1234_5678 -> rdata=32'h1234_5678, err=0.
REQ-042 WR_REG held during WAIT -> gnt_o=0 until the cycle after RESP, then granted; register updated once.
REQ-043 rst_n=0 for one cycle during WAIT, then a stray output_valid_i -> no rvalid, all registers 0, busy_o=0.
